// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dmem_pkg
// Brief   : Shared encodings and lane helpers for the data-memory controller.
// Rev     : 1.0
// ============================================================================
package dmem_pkg;

    localparam int unsigned MEM_BYTES_DEF = 1024;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } dmem_state_t;

    function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                                 input logic [1:0]  lo,
                                                 input logic [1:0]  size,
                                                 input logic        uns);
        logic [31:0] w_b;
        logic [31:0] w_h;
        logic [31:0] w_res;
        w_b = word >> {lo, 3'b000};
        w_h = word >> {lo[1], 4'b0000};
        case (size)
            SZ_B:    w_res = uns ? {24'h0, w_b[7:0]}  : {{24{w_b[7]}}, w_b[7:0]};
            SZ_H:    w_res = uns ? {16'h0, w_h[15:0]} : {{16{w_h[15]}}, w_h[15:0]};
            default: w_res = word;
        endcase
        return w_res;
    endfunction

    // Replace only the addressed byte/half lane of the previously read word.
    function automatic logic [31:0] lane_merge(input logic [31:0] old,
                                               input logic [31:0] wdata,
                                               input logic [1:0]  lo,
                                               input logic [1:0]  size);
        logic [31:0] w_mask;
        logic [31:0] w_data;
        case (size)
            SZ_B: begin
                w_mask = 32'h0000_00FF << {lo, 3'b000};
                w_data = {4{wdata[7:0]}};
            end
            SZ_H: begin
                w_mask = 32'h0000_FFFF << {lo[1], 4'b0000};
                w_data = {2{wdata[15:0]}};
            end
            default: begin
                w_mask = 32'hFFFF_FFFF;
                w_data = wdata;
            end
        endcase
        return (old & ~w_mask) | (w_data & w_mask);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module  : dmem_rr_arb2
// Brief   : Two-requester round-robin arbiter; last grant updates only when enabled.
// Rev     : 1.0
// ============================================================================
module dmem_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_en,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);

    logic r_last_grant;

    always_comb begin
        o_gnt = 2'b00;
        if (i_req[0] && i_req[1]) begin
            o_gnt = r_last_grant ? 2'b01 : 2'b10;
        end else if (i_req[0]) begin
            o_gnt = 2'b01;
        end else if (i_req[1]) begin
            o_gnt = 2'b10;
        end
    end

    // Reset value 1 makes requester 0 win the first contention.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= 1'b1;
        end else if (i_en && (|o_gnt)) begin
            r_last_grant <= o_gnt[1];
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : dmem_ctrl
// Brief   : Load/store sequencer for a single-port word memory with byte/half
//           extract and RMW stores. Debug port m1 enabled by DMEM_CTRL_DEBUG_PORT_EN.
// Rev     : 1.0
// ============================================================================
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned MEM_BYTES = MEM_BYTES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [1:0]  m0_size,
    input  logic        m0_unsigned,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    output logic        m0_ready,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        m1_ready,
    output logic        m1_err,
    output logic        mem_ce,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    dmem_state_t r_state;
    dmem_state_t w_state_nxt;

    logic [1:0]  w_req;
    logic [1:0]  w_gnt;
    logic        w_any;
    logic        w_sel;
    logic        w_sel_we;
    logic        w_sel_uns;
    logic [1:0]  w_sel_size;
    logic [31:0] w_sel_addr;
    logic [31:0] w_sel_wdata;
    logic [31:0] w_sel_aligned;
    logic        w_misalign;
    logic        w_range_ok;
    logic        w_sel_err;
    logic        w_done;
    logic [31:0] w_wr_word;

    logic        r_cmd_port;
    logic        r_cmd_we;
    logic        r_cmd_uns;
    logic [1:0]  r_cmd_size;
    logic [31:0] r_cmd_addr;
    logic [31:0] r_cmd_wdata;
    logic        r_err;
    logic [31:0] r_data;
    logic [31:0] r_m0_rdata;

`ifdef DMEM_CTRL_DEBUG_PORT_EN
    assign w_req = {m1_req, m0_req};
`else
    assign w_req = {1'b0, m0_req};
`endif

    dmem_rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .i_en  (r_state == IDLE),
        .i_req (w_req),
        .o_gnt (w_gnt)
    );

    assign w_any = |w_gnt;
    assign w_sel = w_gnt[1];

    always_comb begin
        w_sel_we    = m0_we;
        w_sel_uns   = m0_unsigned;
        w_sel_size  = m0_size;
        w_sel_addr  = m0_addr;
        w_sel_wdata = m0_wdata;
        if (w_sel) begin
            w_sel_we    = m1_we;
            w_sel_uns   = 1'b0;
            w_sel_size  = SZ_W;
            w_sel_addr  = m1_addr;
            w_sel_wdata = m1_wdata;
        end
    end

    always_comb begin
        case (w_sel_size)
            SZ_B:    w_misalign = 1'b0;
            SZ_H:    w_misalign = w_sel_addr[0];
            SZ_W:    w_misalign = (w_sel_addr[1:0] != 2'b00);
            default: w_misalign = 1'b1;
        endcase
    end

    // 33-bit compare so addresses near 2^32 cannot wrap into range.
    assign w_sel_aligned = {w_sel_addr[31:2], 2'b00};
    assign w_range_ok    = (({1'b0, w_sel_aligned} + 33'd3) < 33'(MEM_BYTES));
    assign w_sel_err     = w_misalign | ~w_range_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    if (w_sel_err) begin
                        w_state_nxt = DONE;
                    end else if (!w_sel_we || (w_sel_size != SZ_W)) begin
                        w_state_nxt = RD;
                    end else begin
                        w_state_nxt = WR;
                    end
                end
            end
            RD:      w_state_nxt = r_cmd_we ? WR : DONE;
            WR:      w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cmd_port  <= 1'b0;
            r_cmd_we    <= 1'b0;
            r_cmd_uns   <= 1'b0;
            r_cmd_size  <= 2'b00;
            r_cmd_addr  <= 32'h0;
            r_cmd_wdata <= 32'h0;
            r_err       <= 1'b0;
            r_data      <= 32'h0;
            r_m0_rdata  <= 32'h0;
        end else begin
            if ((r_state == IDLE) && w_any) begin
                r_cmd_port  <= w_sel;
                r_cmd_we    <= w_sel_we;
                r_cmd_uns   <= w_sel_uns;
                r_cmd_size  <= w_sel_size;
                r_cmd_addr  <= w_sel_addr;
                r_cmd_wdata <= w_sel_wdata;
                r_err       <= w_sel_err;
            end
            if (r_state == RD) begin
                r_data <= mem_rdata;
                if (!r_cmd_we && !r_cmd_port) begin
                    r_m0_rdata <= lane_extract(mem_rdata, r_cmd_addr[1:0], r_cmd_size, r_cmd_uns);
                end
            end
        end
    end

    assign w_wr_word = (r_cmd_size == SZ_W) ? r_cmd_wdata
                     : lane_merge(r_data, r_cmd_wdata, r_cmd_addr[1:0], r_cmd_size);

    assign mem_ce    = (r_state == RD) || (r_state == WR);
    assign mem_we    = (r_state == WR);
    assign mem_addr  = {r_cmd_addr[31:2], 2'b00};
    assign mem_wdata = (r_state == WR) ? w_wr_word : 32'h0;

    assign w_done   = (r_state == DONE);
    assign m0_ready = w_done & ~r_cmd_port;
    assign m0_err   = m0_ready & r_err;
    assign m0_rdata = r_m0_rdata;

`ifdef DMEM_CTRL_DEBUG_PORT_EN
    logic [31:0] r_m1_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m1_rdata <= 32'h0;
        end else if ((r_state == RD) && !r_cmd_we && r_cmd_port) begin
            r_m1_rdata <= mem_rdata;
        end
    end

    assign m1_ready = w_done & r_cmd_port;
    assign m1_err   = m1_ready & r_err;
    assign m1_rdata = r_m1_rdata;
`else
    assign m1_ready = 1'b0;
    assign m1_err   = 1'b0;
    assign m1_rdata = 32'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_dmem_ctrl
// Brief   : Directed self-checking bench for dmem_ctrl with a behavioural memory.
// Rev     : 1.0
// ============================================================================
module tb_dmem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m0_unsigned;
    logic [1:0]  m0_size;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic        m0_ready, m0_err;
    logic        m1_req, m1_we;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic        m1_ready, m1_err;
    logic        mem_ce, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [31:0] mem [0:255];
    int          total = 0;
    int          bad = 0;
    int          wr_count = 0;
    int          m1_rdy_cnt = 0;

    logic        ce_seen;
    int          rd_cyc, we_cyc, lat;
    logic [31:0] wd_seen, rd;
    logic        err;
    int          w0;

    dmem_ctrl #(.MEM_BYTES(1024)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_size(m0_size), .m0_unsigned(m0_unsigned),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rdata(m0_rdata),
        .m0_ready(m0_ready), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_ready(m1_ready), .m1_err(m1_err),
        .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = (mem_addr < 32'd1024) ? mem[mem_addr[9:2]] : 32'hDEAD_BEEF;

    always @(posedge clk) begin
        if (mem_ce && mem_we && (mem_addr < 32'd1024)) begin
            mem[mem_addr[9:2]] = mem_wdata;
            wr_count = wr_count + 1;
        end
    end

    always @(negedge clk) begin
        if (m1_ready) m1_rdy_cnt = m1_rdy_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one m0 access starting in an IDLE cycle; lat counts edges to ready.
    task automatic m0_op(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd);
        @(posedge clk); #1;
        lat = 99; err = 1'b0; rd = 32'h0;
        ce_seen = 1'b0; rd_cyc = 0; we_cyc = 0; wd_seen = 32'h0;
        m0_we = we; m0_size = sz; m0_unsigned = uns; m0_addr = addr; m0_wdata = wd;
        m0_req = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (mem_ce) ce_seen = 1'b1;
            if (mem_ce && !mem_we && rd_cyc == 0) rd_cyc = c;
            if (mem_we) begin
                we_cyc  = c;
                wd_seen = mem_wdata;
            end
            if (m0_ready) begin
                lat = c; err = m0_err; rd = m0_rdata;
                break;
            end
        end
        m0_req = 1'b0;
    endtask

`ifdef DMEM_CTRL_DEBUG_PORT_EN
    task automatic m1_op(input logic we, input logic [31:0] addr, input logic [31:0] wd);
        @(posedge clk); #1;
        lat = 99; err = 1'b0; rd = 32'h0;
        m1_we = we; m1_addr = addr; m1_wdata = wd; m1_req = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (m1_ready) begin
                lat = c; err = m1_err; rd = m1_rdata;
                break;
            end
        end
        m1_req = 1'b0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        m0_req = 1'b0; m0_we = 1'b0; m0_size = 2'b00; m0_unsigned = 1'b0;
        m0_addr = 32'h0; m0_wdata = 32'h0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[4]   = 32'h8899_AABB;
        mem[255] = 32'h5A5A_0FF0;

        #12;
        chk("rst_flags", {26'h0, m0_ready, m0_err, m1_ready, m1_err, mem_ce, mem_we}, 32'h0);
        chk("rst_mem_bus", mem_addr | mem_wdata, 32'h0);
        chk("rst_rdata", m0_rdata | m1_rdata, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Sub-word loads from 0x8899AABB at 0x10
        m0_op(1'b0, 2'b00, 1'b0, 32'h12, 32'h0);
        chk("lb_lat", lat, 2);
        chk("lb_data", rd, 32'hFFFF_FF99);
        chk("lb_err", {31'h0, err}, 32'h0);
        m0_op(1'b0, 2'b00, 1'b1, 32'h12, 32'h0);
        chk("lbu_data", rd, 32'h0000_0099);
        m0_op(1'b0, 2'b01, 1'b0, 32'h10, 32'h0);
        chk("lh_data", rd, 32'hFFFF_AABB);
        m0_op(1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
        chk("lhu_data", rd, 32'h0000_8899);

        // Half store RMW
        m0_op(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000_1234);
        chk("sh_lat", lat, 3);
        chk("sh_rd_cyc", rd_cyc, 1);
        chk("sh_we_cyc", we_cyc, 2);
        chk("sh_wdata", wd_seen, 32'h1234_AABB);
        m0_op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        chk("lw_after_sh", rd, 32'h1234_AABB);
        chk("lw_lat", lat, 2);

        // Byte store ignores upper wdata bits
        m0_op(1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFF_FFCD);
        chk("sb_lat", lat, 3);
        m0_op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        chk("lw_after_sb", rd, 32'h1234_CDBB);

        // Word store
        m0_op(1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFE_F00D);
        chk("sw_lat", lat, 2);
        chk("sw_we_cyc", we_cyc, 1);
        m0_op(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
        chk("lw_after_sw", rd, 32'hCAFE_F00D);

        // Error cases
        m0_op(1'b0, 2'b10, 1'b0, 32'h11, 32'h0);
        chk("misal_w_lat", lat, 1);
        chk("misal_w_err", {31'h0, err}, 32'h1);
        chk("misal_w_noce", {31'h0, ce_seen}, 32'h0);
        m0_op(1'b0, 2'b10, 1'b0, 32'h400, 32'h0);
        chk("range_err", {31'h0, err}, 32'h1);
        chk("range_lat", lat, 1);
        m0_op(1'b0, 2'b01, 1'b0, 32'h13, 32'h0);
        chk("misal_h_err", {31'h0, err}, 32'h1);
        m0_op(1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
        chk("illegal_sz_err", {31'h0, err}, 32'h1);
        w0 = wr_count;
        m0_op(1'b1, 2'b10, 1'b0, 32'h404, 32'h1111_1111);
        chk("err_st_err", {31'h0, err}, 32'h1);
        chk("err_st_nowrite", wr_count, w0);

        // Top-of-memory boundary
        m0_op(1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0);
        chk("top_word_err", {31'h0, err}, 32'h0);
        chk("top_word_data", rd, 32'h5A5A_0FF0);
        m0_op(1'b0, 2'b00, 1'b1, 32'h3FF, 32'h0);
        chk("top_byte_data", rd, 32'h0000_005A);

        // Async reset during WR of a byte store
        @(posedge clk); #1;
        m0_we = 1'b1; m0_size = 2'b00; m0_unsigned = 1'b0; m0_addr = 32'h20; m0_wdata = 32'hEE;
        m0_req = 1'b1;
        we_cyc = 0;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            if (mem_we) begin
                we_cyc = c;
                break;
            end
        end
        chk("rstmid_reach_wr", we_cyc, 2);
        w0 = wr_count;
        rst = 1'b1;
        m0_req = 1'b0;
        #1;
        chk("rstmid_flags", {26'h0, m0_ready, m0_err, m1_ready, m1_err, mem_ce, mem_we}, 32'h0);
        chk("rstmid_bus", mem_addr | mem_wdata, 32'h0);
        chk("rstmid_rdata", m0_rdata | m1_rdata, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rstmid_nowrite", wr_count, w0);
        chk("rstmid_word", mem[8], 32'hCAFE_F00D);

`ifdef DMEM_CTRL_DEBUG_PORT_EN
        begin
            int l0, l1, n;
            logic [31:0] r1;
            logic [3:0]  order;
            // Simultaneous first requests after reset
            @(posedge clk); #1;
            m0_we = 1'b0; m0_size = 2'b10; m0_addr = 32'h10;
            m1_we = 1'b0; m1_addr = 32'h20;
            m0_req = 1'b1; m1_req = 1'b1;
            l0 = 99; l1 = 99; r1 = 32'h0;
            for (int c = 1; c <= 12; c++) begin
                @(posedge clk); #1;
                if (m0_ready && l0 == 99) begin l0 = c; m0_req = 1'b0; end
                if (m1_ready && l1 == 99) begin l1 = c; r1 = m1_rdata; m1_req = 1'b0; end
                if (l0 != 99 && l1 != 99) break;
            end
            m0_req = 1'b0; m1_req = 1'b0;
            chk("arb_m0_lat", l0, 2);
            chk("arb_m1_lat", l1, 5);
            chk("arb_m1_data", r1, 32'hCAFE_F00D);
            chk("arb_m0_data", m0_rdata, 32'h1234_CDBB);

            // Both held: grants alternate starting with m0
            @(posedge clk); #1;
            m0_addr = 32'h10; m1_addr = 32'h3FC;
            m0_req = 1'b1; m1_req = 1'b1;
            n = 0; order = 4'hF;
            for (int c = 1; c <= 20; c++) begin
                @(posedge clk); #1;
                if (m0_ready && n < 4) begin order[n] = 1'b0; n++; end
                else if (m1_ready && n < 4) begin order[n] = 1'b1; n++; end
                if (n == 4) break;
            end
            m0_req = 1'b0; m1_req = 1'b0;
            chk("rr_count", n, 4);
            chk("rr_order", {28'h0, order}, 32'h0000_000A);
        end

        m1_op(1'b0, 32'h22, 32'h0);
        chk("m1_misal_err", {31'h0, err}, 32'h1);
        chk("m1_misal_lat", lat, 1);
        m1_op(1'b1, 32'h30, 32'h0BAD_F00D);
        chk("m1_sw_lat", lat, 2);
        m0_op(1'b0, 2'b10, 1'b0, 32'h30, 32'h0);
        chk("m1_sw_readback", rd, 32'h0BAD_F00D);
`else
        // Debug port disabled: m1 requests must be ignored entirely
        w0 = wr_count;
        m1_we = 1'b1; m1_addr = 32'h30; m1_wdata = 32'h1111_1111;
        m1_req = 1'b1;
        m0_op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        chk("nodbg_m0_lat", lat, 2);
        chk("nodbg_m0_data", rd, 32'h1234_CDBB);
        repeat (6) @(posedge clk);
        #1;
        m1_req = 1'b0;
        chk("nodbg_m1_ready", m1_rdy_cnt, 0);
        chk("nodbg_nowrite", wr_count, w0);
        chk("nodbg_word", mem[12], 32'h0);
        chk("nodbg_rdata", m1_rdata, 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
Load/store controller that sequences the single-port byte-addressed data memory. The memory performs a full 32-bit word access per cycle: combinational read and posedge write.
- Arbitrates between the pipeline MEM-stage port (m0) and a debug/loader port (m1).
- Aligns addresses and checks range.
- Extracts and sign/zero-extends byte/half loads.
- Implements byte/half stores as read-modify-write.

Parameters:
MEM_BYTES, 1024, memory size in bytes; an access is in range iff aligned_addr+3 < MEM_BYTES.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
m0_req  in  1  pipeline request, held stable until m0_ready
m0_we  in  1  1=store, 0=load
m0_size  in  2  00=byte, 01=half, 10=word, 11=illegal
m0_unsigned  in  1  zero-extend load (LBU/LHU)
m0_addr  in  32  byte address
m0_wdata  in  32  store data, LSBs used for byte/half
m0_rdata  out  32  extended load data, valid with m0_ready
m0_ready  out  1  one-cycle completion pulse
m0_err  out  1  with m0_ready: misaligned, out of range or illegal size
m1_req  in  1  debug request (word only), held until m1_ready
m1_we  in  1  1=store
m1_addr  in  32  byte address, must be word aligned
m1_wdata  in  32  store word
m1_rdata  out  32  load word, valid with m1_ready
m1_ready  out  1  one-cycle completion pulse
m1_err  out  1  with m1_ready: misaligned or out of range
mem_ce  out  1  memory enable
mem_we  out  1  memory write enable
mem_addr  out  32  word-aligned byte address ({addr[31:2],2'b00})
mem_wdata  out  32  write word
mem_rdata  in  32  combinational read word

Behaviour:
- FSM states: IDLE, RD, WR, DONE.
- All outputs are registered or decoded from state.
- Reset value of every output is 0. Reset forces the IDLE state and sets last_grant=1, so m0 wins first.
- IDLE: sample requests and pick the winner by 2-way round robin (priority to the port not granted last). Latch the winner's command into cmd registers. Check errors:
  - m0 half requires addr[0]=0; word requires addr[1:0]=0; size 11 is illegal; range per MEM_BYTES.
  - Error → DONE with err=1 and no memory access.
  - Load → RD. Word store → WR. Byte/half store → RD (RMW).
- RD: mem_ce=1, mem_we=0. Capture mem_rdata into the data register at the clock edge.
  - Load → DONE.
  - RMW → WR.
- WR: mem_ce=1, mem_we=1, mem_wdata = full word, or the captured word with the byte lane (addr[1:0]) / half lane (addr[1]) replaced. Write occurs at the edge → DONE.
- DONE: assert the granted port's ready (and err) for exactly one cycle. rdata is held from DONE until the next grant to that port. Return to IDLE; no sampling in DONE.
- Load extraction: byte lane addr[1:0], half lane addr[1]; sign-extend unless m0_unsigned.
- Latency, with req seen in IDLE at cycle N:
  - load / word store: ready at N+2
  - byte/half store: ready at N+3
  - error: ready at N+1
- Back-to-back: a held req is re-sampled at the cycle after ready. Requesters must drop req in the ready cycle unless they are issuing a new access.
- Simultaneous m0/m1 requests: the loser waits; its req is sampled again on the next IDLE.
- Inputs changing while not in IDLE are ignored (command latched).
- Async reset mid-operation: the state goes to IDLE immediately, so mem_we drops before the edge and no partial RMW write occurs. Pending ready is lost; the requester must reissue.

Optional Feature:
DMEM_CTRL_DEBUG_PORT_EN.
- Defined: m1 port is active and round-robin arbitration applies.
- Undefined: m1 inputs are ignored; m1_ready, m1_err and m1_rdata are tied 0; m0 is always granted. The port list is unchanged.

Decomposition:
- Shared package dmem_pkg:
  - size encodings SZ_B/SZ_H/SZ_W
  - FSM state encoding
  - MEM_BYTES default
  - lane-extract/merge functions
- One sub-module, dmem_rr_arb2: 2-requester round-robin arbiter with last_grant register, enabled only in IDLE.

Test Plan:
- Memory word @0x10 = 0x8899AABB; m0 load byte 0x12 signed → m0_rdata=0xFFFFFF99 at N+2; same access unsigned → 0x00000099.
- m0 store half 0x1234 to 0x12 → RD at N+1, WR at N+2 with mem_wdata=0x1234AABB, ready at N+3; word load 0x10 then returns 0x1234AABB.
- m0 word load 0x11 → m0_ready & m0_err at N+1 with mem_ce never asserted; m0 load 0x400 (MEM_BYTES=1024) → err.
- m0 and m1 both request in the same cycle after reset → m0 served first, m1 granted at the next IDLE. Repeat with both held → grants alternate.
- Assert rst during the WR cycle of a byte store → mem_we deasserts immediately, target word unchanged, all outputs 0.
- Build without DMEM_CTRL_DEBUG_PORT_EN, pulse m1_req with a word store → no memory write, m1_ready never asserted.
